// File: rtl/c2h_byp_arb_pkg.sv
// rtl/c2h_byp_arb_pkg.sv - shared types and widths for the C2H ST bypass arbiter
package c2h_byp_arb_pkg;

  localparam int ADDR_W = 64;
  localparam int QID_W  = 11;
  localparam int FUNC_W = 8;
  localparam int PORT_W = 3;
  localparam int TAG_W  = 7;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [QID_W-1:0]  qid;
    logic              error;
    logic [FUNC_W-1:0] func;
    logic [PORT_W-1:0] port_id;
    logic [TAG_W-1:0]  pfch_tag;
  } c2h_st_dsc_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } mrkr_state_e;

endpackage

// File: rtl/rr_arb_core.sv
// rtl/rr_arb_core.sv - round-robin pick with rotating priority pointer
module rr_arb_core #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_REQ-1:0] vld,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [2:0]         gnt_idx,
  output logic               found
);

  logic [2:0] ptr;
  logic [7:0] vld_pad;
  logic [7:0] gnt_pad;
  logic [3:0] cand;

  // Search starts at the pointer and wraps at NUM_REQ, not at 8.
  always_comb begin
    vld_pad              = '0;
    vld_pad[NUM_REQ-1:0] = vld;
    gnt_pad              = '0;
    gnt_idx              = '0;
    found                = 1'b0;
    cand                 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + 4'(i);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      if (!found && vld_pad[cand[2:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[2:0];
      end
    end
    if (en && found) gnt_pad[gnt_idx] = 1'b1;
    gnt = gnt_pad[NUM_REQ-1:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr <= '0;
    end else if (en && found) begin
      if (gnt_idx == 3'(NUM_REQ-1)) ptr <= '0;
      else                          ptr <= gnt_idx + 3'd1;
    end
  end

endmodule

// File: rtl/c2h_byp_st_arb.sv
// rtl/c2h_byp_st_arb.sv - round-robin C2H ST bypass descriptor arbiter with marker sequencing
module c2h_byp_st_arb
  import c2h_byp_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                    axi_aclk,
  input  logic                    axi_aresetn,
  input  logic [NUM_REQ-1:0]      req_vld,
  output logic [NUM_REQ-1:0]      req_rdy,
  input  logic [NUM_REQ*64-1:0]   req_addr,
  input  logic [NUM_REQ*11-1:0]   req_qid,
  input  logic [NUM_REQ*8-1:0]    req_func,
  input  logic [NUM_REQ*3-1:0]    req_port_id,
  input  logic [NUM_REQ*7-1:0]    req_pfch_tag,
  input  logic [NUM_REQ-1:0]      req_error,
  output logic [63:0]             c2h_byp_in_st_csh_addr,
  output logic [10:0]             c2h_byp_in_st_csh_qid,
  output logic                    c2h_byp_in_st_csh_error,
  output logic [7:0]              c2h_byp_in_st_csh_func,
  output logic [2:0]              c2h_byp_in_st_csh_port_id,
  output logic [6:0]              c2h_byp_in_st_csh_pfch_tag,
  output logic                    c2h_byp_in_st_csh_vld,
  input  logic                    c2h_byp_in_st_csh_rdy,
  input  logic                    mrkr_req,
  output logic                    mrkr_out_req,
  input  logic                    c2h_st_marker_rsp,
  output logic                    mrkr_busy,
  output logic                    mrkr_timeout,
  output logic [2:0]              grant_id,
  output logic [31:0]             desc_cnt
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

  mrkr_state_e  state, state_n;
  logic [CNT_W-1:0] tmo_cnt, tmo_cnt_n;
  logic         tmo_set;

  c2h_st_dsc_t  dsc [NUM_REQ];
  c2h_st_dsc_t  win_dsc;
  c2h_st_dsc_t  out_dsc;
  logic         out_vld;
  logic [2:0]   out_id;

  logic         load;
  logic         arb_en;
  logic         take;
  logic         accept;
  logic [NUM_REQ-1:0] gnt;
  logic [2:0]   gnt_idx;
  logic         found;

  assign accept = out_vld && c2h_byp_in_st_csh_rdy;
  assign load   = !out_vld || c2h_byp_in_st_csh_rdy;
  assign arb_en = (state == IDLE) && load;
  assign take   = arb_en && found;

  rr_arb_core #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk     (axi_aclk),
    .resetn  (axi_aresetn),
    .vld     (req_vld),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .found   (found)
  );

  assign req_rdy = gnt;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      dsc[i].addr     = req_addr[64*i +: 64];
      dsc[i].qid      = req_qid[11*i +: 11];
      dsc[i].error    = req_error[i];
      dsc[i].func     = req_func[8*i +: 8];
      dsc[i].port_id  = req_port_id[3*i +: 3];
      dsc[i].pfch_tag = req_pfch_tag[7*i +: 7];
    end
  end

  always_comb begin
    win_dsc = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) win_dsc = dsc[i];
    end
  end

  // Fields only change on a load that carries a grant, so they stay put under backpressure.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      out_vld  <= 1'b0;
      out_dsc  <= '0;
      out_id   <= '0;
      desc_cnt <= '0;
    end else begin
      if (accept) desc_cnt <= desc_cnt + 32'd1;
      if (load) begin
        out_vld <= take;
        if (take) begin
          out_dsc <= win_dsc;
          out_id  <= gnt_idx;
        end
      end
    end
  end

  assign c2h_byp_in_st_csh_vld      = out_vld;
  assign c2h_byp_in_st_csh_addr     = out_dsc.addr;
  assign c2h_byp_in_st_csh_qid      = out_dsc.qid;
  assign c2h_byp_in_st_csh_error    = out_dsc.error;
  assign c2h_byp_in_st_csh_func     = out_dsc.func;
  assign c2h_byp_in_st_csh_port_id  = out_dsc.port_id;
  assign c2h_byp_in_st_csh_pfch_tag = out_dsc.pfch_tag;
  assign grant_id                   = out_id;

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state        <= IDLE;
      tmo_cnt      <= '0;
      mrkr_timeout <= 1'b0;
    end else begin
      state   <= state_n;
      tmo_cnt <= tmo_cnt_n;
      if (tmo_set) mrkr_timeout <= 1'b1;
    end
  end

  // Timeout fires on the cycle the incremented count reaches TIMEOUT_CYC-1.
  always_comb begin
    state_n      = state;
    tmo_cnt_n    = tmo_cnt;
    tmo_set      = 1'b0;
    mrkr_out_req = 1'b0;
    case (state)
      IDLE:  if (mrkr_req) state_n = DRAIN;
      DRAIN: if (!out_vld || c2h_byp_in_st_csh_rdy) state_n = ISSUE;
      ISSUE: begin
        mrkr_out_req = 1'b1;
        tmo_cnt_n    = '0;
        state_n      = WAIT;
      end
      WAIT: begin
        if (c2h_st_marker_rsp) begin
          state_n = IDLE;
        end else begin
          tmo_cnt_n = tmo_cnt + CNT_W'(1);
          if (tmo_cnt == CNT_W'(TIMEOUT_CYC-2)) begin
            tmo_set = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign mrkr_busy = (state != IDLE);

endmodule

// File: tb/tb_c2h_byp_st_arb.sv
// tb/tb_c2h_byp_st_arb.sv - directed self-checking bench for c2h_byp_st_arb
module tb_c2h_byp_st_arb;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic [N-1:0]  req_vld;
  logic [N-1:0]  req_rdy;
  logic [N*64-1:0] req_addr;
  logic [N*11-1:0] req_qid;
  logic [N*8-1:0]  req_func;
  logic [N*3-1:0]  req_port_id;
  logic [N*7-1:0]  req_pfch_tag;
  logic [N-1:0]  req_error;
  logic [63:0]   o_addr;
  logic [10:0]   o_qid;
  logic          o_error;
  logic [7:0]    o_func;
  logic [2:0]    o_port_id;
  logic [6:0]    o_pfch_tag;
  logic          o_vld;
  logic          o_rdy;
  logic          mrkr_req;
  logic          mrkr_out_req;
  logic          mrkr_rsp;
  logic          mrkr_busy;
  logic          mrkr_timeout;
  logic [2:0]    grant_id;
  logic [31:0]   desc_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  c2h_byp_st_arb #(.NUM_REQ(N), .TIMEOUT_CYC(16)) dut (
    .axi_aclk                   (clk),
    .axi_aresetn                (resetn),
    .req_vld                    (req_vld),
    .req_rdy                    (req_rdy),
    .req_addr                   (req_addr),
    .req_qid                    (req_qid),
    .req_func                   (req_func),
    .req_port_id                (req_port_id),
    .req_pfch_tag               (req_pfch_tag),
    .req_error                  (req_error),
    .c2h_byp_in_st_csh_addr     (o_addr),
    .c2h_byp_in_st_csh_qid      (o_qid),
    .c2h_byp_in_st_csh_error    (o_error),
    .c2h_byp_in_st_csh_func     (o_func),
    .c2h_byp_in_st_csh_port_id  (o_port_id),
    .c2h_byp_in_st_csh_pfch_tag (o_pfch_tag),
    .c2h_byp_in_st_csh_vld      (o_vld),
    .c2h_byp_in_st_csh_rdy      (o_rdy),
    .mrkr_req                   (mrkr_req),
    .mrkr_out_req               (mrkr_out_req),
    .c2h_st_marker_rsp          (mrkr_rsp),
    .mrkr_busy                  (mrkr_busy),
    .mrkr_timeout               (mrkr_timeout),
    .grant_id                   (grant_id),
    .desc_cnt                   (desc_cnt)
  );

  function automatic logic [63:0] exp_addr(int i);
    return 64'h1000 + 64'(i) * 64'h100;
  endfunction

  function automatic logic [10:0] exp_qid(int i);
    return 11'(i * 3 + 5);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
    #1;
    n_checks++; if (o_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %0b exp 0", o_vld); end
    n_checks++; if (o_addr !== 64'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", o_addr); end
    n_checks++; if (req_rdy !== 4'b0000) begin n_fail++; $display("FAIL reset_req_rdy got %b exp 0000", req_rdy); end
    n_checks++; if (mrkr_busy !== 1'b0 || mrkr_out_req !== 1'b0 || mrkr_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_mrkr got busy=%0b out=%0b tmo=%0b exp 0", mrkr_busy, mrkr_out_req, mrkr_timeout); end
    n_checks++; if (desc_cnt !== 32'd0 || grant_id !== 3'd0) begin n_fail++; $display("FAIL reset_cnt got cnt=%0d id=%0d exp 0", desc_cnt, grant_id); end
  endtask

  task automatic test_fairness();
    req_vld = 4'hF;
    o_rdy   = 1'b1;
    #1;
    n_checks++; if (req_rdy !== 4'b0001) begin n_fail++; $display("FAIL fair_first_rdy got %b exp 0001", req_rdy); end
    for (int k = 0; k < 8; k++) begin
      step();
      n_checks++; if (o_vld !== 1'b1 || grant_id !== 3'(k % 4)) begin n_fail++; $display("FAIL fair_grant k=%0d got vld=%0b id=%0d exp vld=1 id=%0d", k, o_vld, grant_id, k % 4); end
      n_checks++; if (o_addr !== exp_addr(k % 4) || o_qid !== exp_qid(k % 4)) begin n_fail++; $display("FAIL fair_data k=%0d got %h/%0d exp %h/%0d", k, o_addr, o_qid, exp_addr(k % 4), exp_qid(k % 4)); end
      n_checks++; if (req_rdy !== 4'(1 << ((k + 1) % 4))) begin n_fail++; $display("FAIL fair_rdy k=%0d got %b", k, req_rdy); end
      n_checks++; if (desc_cnt !== 32'(k)) begin n_fail++; $display("FAIL fair_cnt k=%0d got %0d exp %0d", k, desc_cnt, k); end
    end
    req_vld = 4'h0;
    step();
    n_checks++; if (desc_cnt !== 32'd8 || o_vld !== 1'b0) begin n_fail++; $display("FAIL fair_total got cnt=%0d vld=%0b exp 8/0", desc_cnt, o_vld); end
  endtask

  task automatic test_backpressure();
    o_rdy   = 1'b0;
    req_vld = 4'b0001;
    step();
    req_vld = 4'b0110;
    #1;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (o_vld !== 1'b1 || o_addr !== 64'h1000 || grant_id !== 3'd0) begin n_fail++; $display("FAIL bp_hold k=%0d got vld=%0b addr=%h id=%0d", k, o_vld, o_addr, grant_id); end
      n_checks++; if (req_rdy !== 4'b0000 || desc_cnt !== 32'd8) begin n_fail++; $display("FAIL bp_block k=%0d got rdy=%b cnt=%0d exp 0000/8", k, req_rdy, desc_cnt); end
      step();
    end
    o_rdy = 1'b1;
    #1;
    n_checks++; if (req_rdy !== 4'b0010) begin n_fail++; $display("FAIL bp_release_rdy got %b exp 0010", req_rdy); end
    step();
    req_vld = 4'b0100;
    #1;
    n_checks++; if (desc_cnt !== 32'd9 || grant_id !== 3'd1 || o_addr !== exp_addr(1)) begin n_fail++; $display("FAIL bp_b2b1 got cnt=%0d id=%0d addr=%h", desc_cnt, grant_id, o_addr); end
    n_checks++; if (req_rdy !== 4'b0100) begin n_fail++; $display("FAIL bp_b2b_rdy got %b exp 0100", req_rdy); end
    step();
    req_vld = 4'b0000;
    n_checks++; if (desc_cnt !== 32'd10 || grant_id !== 3'd2 || o_vld !== 1'b1) begin n_fail++; $display("FAIL bp_b2b2 got cnt=%0d id=%0d vld=%0b", desc_cnt, grant_id, o_vld); end
    step();
    n_checks++; if (desc_cnt !== 32'd11 || o_vld !== 1'b0) begin n_fail++; $display("FAIL bp_drain got cnt=%0d vld=%0b exp 11/0", desc_cnt, o_vld); end
  endtask

  task automatic test_wrap_skip();
    req_vld = 4'b0010;
    step();
    req_vld = 4'b0000;
    step();
    req_vld = 4'b1010;
    #1;
    n_checks++; if (req_rdy !== 4'b1000) begin n_fail++; $display("FAIL wrap_first_rdy got %b exp 1000", req_rdy); end
    step();
    req_vld = 4'b0010;
    #1;
    n_checks++; if (grant_id !== 3'd3 || req_rdy !== 4'b0010) begin n_fail++; $display("FAIL wrap_grant3 got id=%0d rdy=%b exp 3/0010", grant_id, req_rdy); end
    step();
    req_vld = 4'b0000;
    n_checks++; if (grant_id !== 3'd1 || o_addr !== exp_addr(1)) begin n_fail++; $display("FAIL wrap_grant1 got id=%0d addr=%h", grant_id, o_addr); end
    step();
    req_vld = 4'hF;
    #1;
    n_checks++; if (req_rdy !== 4'b0100) begin n_fail++; $display("FAIL wrap_ptr got %b exp 0100", req_rdy); end
    n_checks++; if (desc_cnt !== 32'd14) begin n_fail++; $display("FAIL wrap_cnt got %0d exp 14", desc_cnt); end
    req_vld = 4'h0;
    #1;
  endtask

  task automatic test_marker_normal();
    o_rdy   = 1'b0;
    req_vld = 4'b0001;
    step();
    req_vld  = 4'hF;
    mrkr_req = 1'b1;
    step();
    mrkr_req = 1'b0;
    n_checks++; if (mrkr_busy !== 1'b1 || o_vld !== 1'b1 || grant_id !== 3'd0) begin n_fail++; $display("FAIL mk_drain got busy=%0b vld=%0b id=%0d", mrkr_busy, o_vld, grant_id); end
    o_rdy = 1'b1;
    #1;
    n_checks++; if (req_rdy !== 4'b0000 || mrkr_out_req !== 1'b0) begin n_fail++; $display("FAIL mk_nogrant got rdy=%b out=%0b", req_rdy, mrkr_out_req); end
    step();
    n_checks++; if (mrkr_out_req !== 1'b1 || o_vld !== 1'b0 || req_rdy !== 4'b0000) begin n_fail++; $display("FAIL mk_issue got out=%0b vld=%0b rdy=%b", mrkr_out_req, o_vld, req_rdy); end
    for (int k = 0; k < 9; k++) begin
      step();
      n_checks++; if (mrkr_out_req !== 1'b0 || mrkr_busy !== 1'b1 || req_rdy !== 4'b0000) begin n_fail++; $display("FAIL mk_wait k=%0d got out=%0b busy=%0b rdy=%b", k, mrkr_out_req, mrkr_busy, req_rdy); end
    end
    step();
    mrkr_rsp = 1'b1;
    step();
    mrkr_rsp = 1'b0;
    #1;
    n_checks++; if (mrkr_busy !== 1'b0 || mrkr_timeout !== 1'b0) begin n_fail++; $display("FAIL mk_done got busy=%0b tmo=%0b exp 0/0", mrkr_busy, mrkr_timeout); end
    n_checks++; if (req_rdy !== 4'b0010) begin n_fail++; $display("FAIL mk_resume_rdy got %b exp 0010", req_rdy); end
    step();
    req_vld = 4'h0;
    n_checks++; if (o_vld !== 1'b1 || grant_id !== 3'd1 || desc_cnt !== 32'd15) begin n_fail++; $display("FAIL mk_resume got vld=%0b id=%0d cnt=%0d", o_vld, grant_id, desc_cnt); end
    step();
  endtask

  task automatic test_marker_timeout();
    mrkr_req = 1'b1;
    step();
    mrkr_req = 1'b0;
    step();
    n_checks++; if (mrkr_out_req !== 1'b1) begin n_fail++; $display("FAIL tmo_issue got %0b exp 1", mrkr_out_req); end
    for (int k = 1; k <= 15; k++) begin
      mrkr_req = (k == 5);
      step();
      n_checks++; if (mrkr_timeout !== 1'b0 || mrkr_busy !== 1'b1) begin n_fail++; $display("FAIL tmo_early k=%0d got tmo=%0b busy=%0b", k, mrkr_timeout, mrkr_busy); end
    end
    mrkr_req = 1'b0;
    step();
    n_checks++; if (mrkr_timeout !== 1'b1 || mrkr_busy !== 1'b0) begin n_fail++; $display("FAIL tmo_fire got tmo=%0b busy=%0b exp 1/0", mrkr_timeout, mrkr_busy); end
    mrkr_rsp = 1'b1;
    step();
    mrkr_rsp = 1'b0;
    n_checks++; if (mrkr_timeout !== 1'b1 || mrkr_busy !== 1'b0) begin n_fail++; $display("FAIL tmo_sticky got tmo=%0b busy=%0b exp 1/0", mrkr_timeout, mrkr_busy); end
  endtask

  task automatic test_reset_mid();
    mrkr_req = 1'b1;
    step();
    mrkr_req = 1'b0;
    step();
    step();
    n_checks++; if (mrkr_busy !== 1'b1 || mrkr_out_req !== 1'b0) begin n_fail++; $display("FAIL rst_inwait got busy=%0b out=%0b exp 1/0", mrkr_busy, mrkr_out_req); end
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    n_checks++; if (mrkr_busy !== 1'b0 || mrkr_timeout !== 1'b0 || desc_cnt !== 32'd0 || o_vld !== 1'b0) begin n_fail++; $display("FAIL rst_wait got busy=%0b tmo=%0b cnt=%0d vld=%0b", mrkr_busy, mrkr_timeout, desc_cnt, o_vld); end
    o_rdy   = 1'b0;
    req_vld = 4'b0100;
    step();
    req_vld = 4'b0000;
    n_checks++; if (o_vld !== 1'b1 || grant_id !== 3'd2) begin n_fail++; $display("FAIL rst_load got vld=%0b id=%0d exp 1/2", o_vld, grant_id); end
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    n_checks++; if (o_vld !== 1'b0 || grant_id !== 3'd0 || o_addr !== 64'h0) begin n_fail++; $display("FAIL rst_vld got vld=%0b id=%0d addr=%h", o_vld, grant_id, o_addr); end
    req_vld = 4'hF;
    #1;
    n_checks++; if (req_rdy !== 4'b0001) begin n_fail++; $display("FAIL rst_ptr got %b exp 0001", req_rdy); end
    req_vld = 4'h0;
  endtask

  initial begin
    resetn   = 1'b0;
    req_vld  = '0;
    o_rdy    = 1'b0;
    mrkr_req = 1'b0;
    mrkr_rsp = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_addr[64*i +: 64]    = exp_addr(i);
      req_qid[11*i +: 11]     = exp_qid(i);
      req_func[8*i +: 8]      = 8'(8'h40 + i);
      req_port_id[3*i +: 3]   = 3'(i);
      req_pfch_tag[7*i +: 7]  = 7'(i + 9);
      req_error[i]            = (i == 2);
    end
    test_reset();
    test_fairness();
    test_backpressure();
    test_wrap_skip();
    test_marker_normal();
    test_marker_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
